// File: rtl/mem_stage.sv
// mem_stage: RV32I memory-access stage; clk/rst, EX/MEM word in, dmem req/resp handshake, stall out, registered MEM/WB word, load data and misaligned flag out
package rv32i_pkg;
  typedef enum logic [6:0] {
    op_none  = 7'b0000000,
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011
  } rv32i_opcode;
  typedef struct packed {
    rv32i_opcode opcode;
    logic [3:0]  mem_byte_enable;
    logic [2:0]  store_type;
    logic [2:0]  load_type;
  } ctrl_word;
  typedef struct packed {
    logic        valid;
    ctrl_word    ctrl;
    logic [31:0] pc;
    logic [2:0]  funct3;
    logic [31:0] alu;
    logic [31:0] rs2;
    logic [4:0]  rd;
  } stage_regs;
endpackage

module mem_stage
  import rv32i_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  stage_regs   ex_mem_in,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] dmem_address,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_byte_enable,
  output logic        stall,
  output stage_regs   mem_wb_out,
  output logic [31:0] mem_wb_rdata,
  output logic        mem_wb_misaligned
);
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t state, next_state;
  stage_regs lat;
  logic [31:0] addr, wdata, wdata_fmt, sel, load_fmt;
  logic [3:0] mask, mask_fmt;
  logic is_write, is_mem, is_store, misaligned, req_ok;
  logic [1:0] off;
  logic [1:0] sz;
  // funct3[1:0] encodes access size for both loads and stores
  always_comb begin
    off = ex_mem_in.alu[1:0];
    sz = ex_mem_in.funct3[1:0];
    is_store = ex_mem_in.ctrl.opcode == op_store;
    is_mem = ex_mem_in.valid & (is_store | ex_mem_in.ctrl.opcode == op_load);
    misaligned = (sz == 2'b01 & off[0]) | (sz == 2'b10 & off != 2'b00);
    req_ok = is_mem & ~misaligned;
    wdata_fmt = sz == 2'b00 ? {4{ex_mem_in.rs2[7:0]}} :
                sz == 2'b01 ? {2{ex_mem_in.rs2[15:0]}} : ex_mem_in.rs2;
    mask_fmt = ~is_store ? 4'b1111 :
               sz == 2'b00 ? 4'b0001 << off :
               sz == 2'b01 ? 4'b0011 << off : 4'b1111;
    sel = dmem_rdata >> {lat.alu[1:0], 3'b000};
    load_fmt = lat.funct3 == 3'b000 ? {{24{sel[7]}}, sel[7:0]} :
               lat.funct3 == 3'b100 ? {24'b0, sel[7:0]} :
               lat.funct3 == 3'b001 ? {{16{sel[15]}}, sel[15:0]} :
               lat.funct3 == 3'b101 ? {16'b0, sel[15:0]} : dmem_rdata;
    stall = state == IDLE ? req_ok : ~dmem_resp;
    next_state = state == IDLE ? (req_ok ? ACCESS : IDLE) : (dmem_resp ? IDLE : ACCESS);
    dmem_read = state == ACCESS & ~is_write;
    dmem_write = state == ACCESS & is_write;
    dmem_address = addr;
    dmem_wdata = wdata;
    dmem_byte_enable = mask;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      lat <= '0;
      addr <= '0;
      wdata <= '0;
      mask <= '0;
      is_write <= 1'b0;
      mem_wb_out <= '0;
      mem_wb_rdata <= '0;
      mem_wb_misaligned <= 1'b0;
    end else begin
      state <= next_state;
      if (state == IDLE && req_ok) begin
        lat <= ex_mem_in;
        addr <= {ex_mem_in.alu[31:2], 2'b00};
        wdata <= wdata_fmt;
        mask <= mask_fmt;
        is_write <= is_store;
      end
      // a stalled edge inserts a bubble so WB never sees the same word twice
      if (stall) begin
        mem_wb_out.valid <= 1'b0;
      end else if (state == IDLE) begin
        mem_wb_out <= ex_mem_in;
        mem_wb_rdata <= '0;
        mem_wb_misaligned <= is_mem & misaligned;
      end else begin
        mem_wb_out <= lat;
        mem_wb_rdata <= is_write ? 32'h0 : load_fmt;
        mem_wb_misaligned <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage
module tb_mem_stage;
  import rv32i_pkg::*;
  logic clk = 0, rst = 1;
  stage_regs ex_mem_in, mem_wb_out;
  logic [31:0] dmem_rdata, dmem_address, dmem_wdata, mem_wb_rdata;
  logic dmem_resp, dmem_read, dmem_write, stall, mem_wb_misaligned;
  logic [3:0] dmem_byte_enable;
  int tests = 0, fails = 0, vcnt = 0, v0;
  mem_stage dut (
    .clk(clk), .rst(rst), .ex_mem_in(ex_mem_in), .dmem_rdata(dmem_rdata),
    .dmem_resp(dmem_resp), .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_address(dmem_address), .dmem_wdata(dmem_wdata),
    .dmem_byte_enable(dmem_byte_enable), .stall(stall), .mem_wb_out(mem_wb_out),
    .mem_wb_rdata(mem_wb_rdata), .mem_wb_misaligned(mem_wb_misaligned)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (!rst && mem_wb_out.valid) vcnt++;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic stage_regs mk(input rv32i_opcode op, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] r);
    stage_regs s;
    s = '0;
    s.valid = 1'b1;
    s.ctrl.opcode = op;
    s.ctrl.mem_byte_enable = 4'b0101;
    s.funct3 = f3;
    s.alu = a;
    s.rs2 = r;
    s.rd = 5'd7;
    return s;
  endfunction
  function automatic stage_regs nop();
    stage_regs s;
    s = mk(op_imm, 3'b000, 32'h0, 32'h0);
    s.valid = 1'b0;
    return s;
  endfunction
  task automatic mem_op(input string tag, input stage_regs s, input int waits, input logic [31:0] rdata,
                        input logic [31:0] e_addr, input logic [31:0] e_wdata, input logic [3:0] e_mask,
                        input logic [31:0] e_rdata);
    logic w;
    w = s.ctrl.opcode == op_store;
    ex_mem_in = s;
    #1 chk({tag, "_req_stall"}, stall, 1);
    chk({tag, "_req_idle"}, dmem_read | dmem_write, 0);
    tick;
    for (int i = 0; i < waits; i++) begin
      chk({tag, "_wait_stall"}, stall, 1);
      chk({tag, "_wait_rw"}, {dmem_read, dmem_write}, {~w, w});
      chk({tag, "_wait_addr"}, dmem_address, e_addr);
      tick;
    end
    dmem_resp = 1;
    dmem_rdata = rdata;
    #1 chk({tag, "_resp_stall"}, stall, 0);
    chk({tag, "_rw"}, {dmem_read, dmem_write}, {~w, w});
    chk({tag, "_addr"}, dmem_address, e_addr);
    chk({tag, "_wdata"}, dmem_wdata, e_wdata);
    chk({tag, "_mask"}, dmem_byte_enable, e_mask);
    tick;
    dmem_resp = 0;
    dmem_rdata = 32'h0;
    ex_mem_in = nop();
    #1 chk({tag, "_wb_valid"}, mem_wb_out.valid, 1);
    chk({tag, "_wb_alu"}, mem_wb_out.alu, s.alu);
    chk({tag, "_wb_rdata"}, mem_wb_rdata, e_rdata);
    chk({tag, "_wb_mis"}, mem_wb_misaligned, 0);
    chk({tag, "_idle_rw"}, dmem_read | dmem_write, 0);
  endtask
  initial begin
    ex_mem_in = nop();
    dmem_rdata = 0;
    dmem_resp = 0;
    #1;
    chk("rst_valid", mem_wb_out.valid, 0);
    chk("rst_rdata", mem_wb_rdata, 0);
    chk("rst_mis", mem_wb_misaligned, 0);
    chk("rst_rw", {dmem_read, dmem_write}, 0);
    chk("rst_addr", dmem_address, 0);
    chk("rst_wdata", dmem_wdata, 0);
    chk("rst_mask", dmem_byte_enable, 0);
    chk("rst_stall", stall, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    tick;
    v0 = vcnt;
    mem_op("sw", mk(op_store, 3'b010, 32'h100, 32'hDEADBEEF), 3, 32'h0, 32'h100, 32'hDEADBEEF, 4'b1111, 32'h0);
    tick;
    chk("sw_bubble", mem_wb_out.valid, 0);
    chk("sw_one_word", vcnt - v0, 1);
    mem_op("sb", mk(op_store, 3'b000, 32'h203, 32'h000000A5), 0, 32'h0, 32'h200, 32'hA5A5A5A5, 4'b1000, 32'h0);
    mem_op("sh", mk(op_store, 3'b001, 32'h206, 32'h00001234), 1, 32'h0, 32'h204, 32'h12341234, 4'b1100, 32'h0);
    mem_op("lb", mk(op_load, 3'b000, 32'h300, 32'h0), 0, 32'h8070F0FF, 32'h300, 32'h0, 4'b1111, 32'hFFFFFFFF);
    mem_op("lbu", mk(op_load, 3'b100, 32'h301, 32'h0), 0, 32'h8070F0FF, 32'h300, 32'h0, 4'b1111, 32'h000000F0);
    mem_op("lh", mk(op_load, 3'b001, 32'h302, 32'h0), 1, 32'h8070F0FF, 32'h300, 32'h0, 4'b1111, 32'hFFFF8070);
    mem_op("lhu", mk(op_load, 3'b101, 32'h302, 32'h0), 0, 32'h8070F0FF, 32'h300, 32'h0, 4'b1111, 32'h00008070);
    mem_op("lw", mk(op_load, 3'b010, 32'h304, 32'h0), 2, 32'h8070F0FF, 32'h304, 32'h0, 4'b1111, 32'h8070F0FF);
    tick;
    ex_mem_in = mk(op_load, 3'b010, 32'h102, 32'h0);
    #1 chk("mis_stall", stall, 0);
    chk("mis_read", dmem_read, 0);
    tick;
    ex_mem_in = nop();
    #1 chk("mis_flag", mem_wb_misaligned, 1);
    chk("mis_rdata", mem_wb_rdata, 0);
    chk("mis_valid", mem_wb_out.valid, 1);
    chk("mis_noread", dmem_read, 0);
    tick;
    chk("mis_flag_clr", mem_wb_misaligned, 0);
    v0 = vcnt;
    for (int k = 0; k < 2; k++) begin
      ex_mem_in = mk(op_reg, 3'b000, 32'h55 + k, 32'h0);
      #1 chk("add_stall", stall, 0);
      tick;
      chk("add_valid", mem_wb_out.valid, 1);
      chk("add_alu", mem_wb_out.alu, 32'h55 + k);
      mem_op("alt_lw", mk(op_load, 3'b010, 32'h500 + 4 * k, 32'h0), 0, 32'h11110000 + k, 32'h500 + 4 * k, 32'h0, 4'b1111, 32'h11110000 + k);
    end
    tick;
    chk("alt_count", vcnt - v0, 4);
    ex_mem_in = mk(op_load, 3'b010, 32'h400, 32'h0);
    tick;
    chk("rst_mid_read", dmem_read, 1);
    rst = 1;
    #1 chk("rst_mid_drop", dmem_read, 0);
    chk("rst_mid_addr", dmem_address, 0);
    chk("rst_mid_valid", mem_wb_out.valid, 0);
    ex_mem_in = nop();
    @(negedge clk);
    rst = 0;
    v0 = vcnt;
    tick;
    dmem_resp = 1;
    dmem_rdata = 32'hCAFEF00D;
    tick;
    dmem_resp = 0;
    #1 chk("late_resp_read", dmem_read, 0);
    chk("late_resp_rdata", mem_wb_rdata, 0);
    tick;
    tick;
    chk("late_resp_count", vcnt - v0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
